// File: rtl/gather_c.sv
// gather_c: write-back of one C tile from the systolic array into BRAM.
// Each accepted row of N signed accumulators is arithmetically shifted
// right by SHIFT, saturated to W bits per lane, packed, and written to
// BRAM with a 1-cycle latency at consecutive, wrapping word addresses.
//
// Optional feature macro: GATHER_C_RELU_EN (clamps negative lanes to 0
// before the shift).
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   start_wb       in   pulse: start writing back one tile (IDLE only)
//   c_in           in   [N-1:0][ACC_W-1:0] signed accumulator row
//   c_valid        in   c_in valid
//   c_ready        out  row accepted this cycle (RUN only)
//   bram_clk_c     out  BRAM clock (= clk)
//   bram_we_c      out  BRAM write enable
//   bram_addr_c    out  BRAM word address
//   bram_wrdata_c  out  BRAM write data
//   bram_rddata_c  in   BRAM read data (unused)
//   busy           out  not in IDLE
//   wb_done        out  pulse one cycle after the last write

module gather_c #(
  parameter int W             = 8,
  parameter int N             = 16,
  parameter int ACC_W         = 32,
  parameter int BRAM_W        = 128,
  parameter int BRAM_AW       = 9,
  parameter int DATA_A_SIZE_Y = 64,
  parameter int DATA_B_SIZE_X = 64,
  parameter int SHIFT         = 8,
  parameter int BASE_ADDR     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_wb,
  input  logic [N-1:0][ACC_W-1:0]   c_in,
  input  logic                      c_valid,
  output logic                      c_ready,
  output logic                      bram_clk_c,
  output logic                      bram_we_c,
  output logic [BRAM_AW-1:0]        bram_addr_c,
  output logic [BRAM_W-1:0]         bram_wrdata_c,
  input  logic [BRAM_W-1:0]         bram_rddata_c,
  output logic                      busy,
  output logic                      wb_done
);

  localparam int TOTAL = DATA_A_SIZE_Y * DATA_B_SIZE_X / N;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [CW-1:0]      LAST  = CW'(TOTAL - 1);
  localparam logic [BRAM_AW-1:0] BASE  = BRAM_AW'(BASE_ADDR);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] QMAX =
    {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] QMIN =
    {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]      cnt_q;
  logic [BRAM_AW-1:0] addr_q;
  logic               xfer;
  logic               last;
  logic [BRAM_W-1:0]  packed_row;

  logic signed [ACC_W-1:0] lane;
  logic signed [ACC_W-1:0] shr;
  logic        [W-1:0]     qv;

  // There is no read path; the BRAM read port is tied off here.
  logic unused_rd;
  assign unused_rd = ^bram_rddata_c;

  assign bram_clk_c = clk;
  assign xfer       = c_valid & c_ready;
  assign last       = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_ready = 1'b0;
    busy    = 1'b0;
    wb_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_wb) state_d = RUN;
      end
      RUN: begin
        c_ready = 1'b1;
        busy    = 1'b1;
        if (xfer && last) state_d = FLUSH;
      end
      FLUSH: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        wb_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-lane shift + saturate; shift is arithmetic so it floors.
  always_comb begin
    packed_row = '0;
    lane       = '0;
    shr        = '0;
    qv         = '0;
    for (int i = 0; i < N; i++) begin
      lane = $signed(c_in[i]);
`ifdef GATHER_C_RELU_EN
      if (lane[ACC_W-1]) lane = '0;
`endif
      shr = lane >>> SHIFT;
      if (shr > QMAX) begin
        qv = QMAX[W-1:0];
      end else if (shr < QMIN) begin
        qv = QMIN[W-1:0];
      end else begin
        qv = shr[W-1:0];
      end
      packed_row[i*W +: W] = qv;
    end
  end

  // Word counter and write address; address wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      addr_q <= BASE;
    end else if (state_q == IDLE && start_wb) begin
      cnt_q  <= '0;
      addr_q <= BASE;
    end else if (xfer) begin
      cnt_q  <= cnt_q + 1'b1;
      addr_q <= addr_q + 1'b1;
    end
  end

  // Registered BRAM port: one write in the cycle after each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_we_c     <= 1'b0;
      bram_addr_c   <= '0;
      bram_wrdata_c <= '0;
    end else begin
      bram_we_c <= xfer;
      if (xfer) begin
        bram_addr_c   <= addr_q;
        bram_wrdata_c <= packed_row;
      end
    end
  end

endmodule
